nla_input_scheduler: RTL and testbench

Sequencer and port arbiter for the engine's input FIFO. Accepts FP32 operands from the host stream, writes them into the FIFO, and detects the NaN start marker (or a full FIFO) as the end of a burst. It then drains exactly the buffered words into the approximation datapath over a valid/ready interface with `m_last` on the final word. The FIFO's single status register serves one port per cycle, so the block never drives write and read in the same cycle.

---
 rtl/nla_input_scheduler.sv | 174 +++++++++++++++++
 tb/tb_nla_input_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nla_input_scheduler.sv
// Input sequencer/arbiter for the approximation engine's FIFO: fills a burst, then drains it.
// Optional idle-timeout forced drain is compiled in with `define NLA_SCHED_TIMEOUT_EN.
module nla_input_scheduler #(
    parameter int                   RAM_WIDTH   = 32,
    parameter int                   ADDR_LINES  = 5,
    parameter logic [RAM_WIDTH-1:0] START_WORD  = 32'h7F90_0000,
    parameter int                   TIMEOUT_CYC = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 s_valid,
    input  logic [RAM_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 fifo_wr_en,
    output logic [RAM_WIDTH-1:0] fifo_data_i,
    output logic                 fifo_rd_en,
    input  logic [RAM_WIDTH-1:0] fifo_data_o,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int D  = 2 ** ADDR_LINES;
    localparam int CW = ADDR_LINES + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        rem_q;
    logic [CW-1:0]        popped_q;
    logic                 alive_q;
    logic                 err_q;
    logic                 inflight_q;
    logic [1:0]           occ_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [RAM_WIDTH-1:0] obuf_q [2];
    logic                 is_marker;
    logic                 pop;
    logic [2:0]           used_slots;
    logic                 idle_hit;

    assign is_marker   = (s_data == START_WORD);
    assign fifo_data_i = s_data;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

`ifdef NLA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q;

    assign idle_hit = (state_q == FILL) && !s_valid && (idle_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idle_q <= '0;
        end else if ((state_q != FILL) || (s_valid && s_ready)) begin
            idle_q <= '0;
        end else if (!s_valid) begin
            idle_q <= idle_q + TW'(1);
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    // Output buffer: a slot is reserved from read issue until the engine takes the word.
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = obuf_q[rd_ptr_q];
    assign pop        = m_valid && m_ready;
    assign used_slots = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = (state_q == DRAIN) && (rem_q != '0) && (used_slots < 3'd2);
    assign m_last     = m_valid && (state_q == DRAIN) && (popped_q == cnt_q - CW'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_ready    = 1'b0;
        fifo_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready = alive_q;
                if (s_valid && alive_q && !is_marker) begin
                    fifo_wr_en = 1'b1;
                    cnt_d      = CW'(1);
                    state_d    = FILL;
                end
            end
            FILL: begin
                s_ready = ~fifo_full;
                if (s_valid && !fifo_full) begin
                    if (is_marker) begin
                        state_d = DRAIN;
                    end else begin
                        fifo_wr_en = 1'b1;
                        cnt_d      = cnt_q + CW'(1);
                        if (cnt_q == CW'(D - 1)) state_d = DRAIN;
                    end
                end else if (idle_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            popped_q   <= '0;
            alive_q    <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alive_q    <= 1'b1;
            inflight_q <= fifo_rd_en;
            if (fifo_rd_en && fifo_empty) err_q <= 1'b1;
            if ((state_d == DRAIN) && (state_q != DRAIN)) begin
                rem_q <= cnt_d;
            end else if (fifo_rd_en) begin
                rem_q <= rem_q - CW'(1);
            end
            if (pop && m_last) begin
                popped_q <= '0;
            end else if (pop) begin
                popped_q <= popped_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            occ_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
        end else begin
            if (inflight_q) begin
                obuf_q[wr_ptr_q] <= fifo_data_o;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({inflight_q, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_nla_input_scheduler.sv
// Directed bench for nla_input_scheduler with a behavioural FIFO and an in-order scoreboard.
module tb_nla_input_scheduler;

    localparam logic [31:0] MARK = 32'h7F90_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [31:0] fifo_data_i;
    logic        fifo_rd_en;
    logic [31:0] fifo_data_o;
    logic        fifo_full;
    logic        fifo_empty;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy_o;
    logic        err_o;

    logic        force_empty;
    logic [31:0] mem [32];
    logic [4:0]  wp, rp;
    logic [5:0]  fcount;

    int          n_checks = 0;
    int          n_errors = 0;
    int          out_cnt = 0;
    logic [31:0] exp_q[$];

    nla_input_scheduler dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_data_i (fifo_data_i),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data_o (fifo_data_o),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // External FIFO model: registered read data, one cycle after fifo_rd_en
    assign fifo_full  = (fcount == 6'd32);
    assign fifo_empty = (fcount == 6'd0) || force_empty;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wp          <= '0;
            rp          <= '0;
            fcount      <= '0;
            fifo_data_o <= '0;
        end else begin
            if (fifo_wr_en) begin
                mem[wp] <= fifo_data_i;
                wp      <= wp + 5'd1;
            end
            if (fifo_rd_en) begin
                fifo_data_o <= mem[rp];
                rp          <= rp + 5'd1;
            end
            fcount <= fcount + {5'd0, fifo_wr_en} - {5'd0, fifo_rd_en};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle
    always @(negedge clk_i) begin : monitor
        logic [31:0] e;
        logic        p;
        if (rstn_i) begin
            p = m_valid && m_ready;
            if (p) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", m_data, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check_val("m_data", m_data, e);
                    check_val("m_last", {31'd0, m_last}, {31'd0, exp_q.size() == 0});
                end
            end
            if (fifo_rd_en) begin
                check_val("wr_rd_overlap", {31'd0, fifo_wr_en}, 32'd0);
                check_val("outstanding", {31'd0, (out_cnt - int'(p) + 1) <= 2}, 32'd1);
            end
            out_cnt = out_cnt - int'(p) + int'(fifo_rd_en);
        end
    end

    // Driver tasks: called and returning at posedge + 1
    task automatic send_word(input logic [31:0] w, input bit is_mark);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = s_ready;
            @(posedge clk_i);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check_val("send_accept", {31'd0, acc}, 32'd1);
        if (acc && !is_mark) exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < budget);
        check_val("idle_timeout", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check_val("rst_wr_en",   {31'd0, fifo_wr_en}, 32'd0);
        check_val("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_val("rst_m_data",  m_data, 32'd0);
        check_val("rst_m_last",  {31'd0, m_last}, 32'd0);
        check_val("rst_busy",    {31'd0, busy_o}, 32'd0);
        check_val("rst_err",     {31'd0, err_o}, 32'd0);
        check_val("rst_fdata",   fifo_data_i, 32'd0);
    endtask

    task automatic do_reset_release();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_val("rel_s_ready", {31'd0, s_ready}, 32'd1);
        check_val("rel_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] words [3];
        bit          rd_seq [4];
        bit          mv_seq [4];
        bit          pat [4];
        words  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        rd_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
        mv_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

        rstn_i      = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs();
        do_reset_release();

        // Basic burst with exact read/valid timing after the marker
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        send_word(MARK, 1);
        check_val("mark_busy", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_val("basic_rd_en", {31'd0, fifo_rd_en}, {31'd0, rd_seq[i]});
            check_val("basic_m_valid", {31'd0, m_valid}, {31'd0, mv_seq[i]});
        end
        @(negedge clk_i);
        check_val("basic_last_cycle", {31'd0, m_last}, 32'd1);
        @(negedge clk_i);
        check_val("basic_end_busy", {31'd0, busy_o}, 32'd0);
        check_val("basic_end_sready", {31'd0, s_ready}, 32'd1);
        @(posedge clk_i);
        #1;
        check_val("basic_drained", exp_q.size(), 32'd0);

        // Backpressure: m_ready cycles 1,0,0,1
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        send_word(MARK, 1);
        for (int i = 0; i < 40; i++) begin
            m_ready = pat[i % 4];
            @(negedge clk_i);
            if (!busy_o) break;
            @(posedge clk_i);
            #1;
        end
        check_val("bp_idle", {31'd0, busy_o}, 32'd0);
        check_val("bp_drained", exp_q.size(), 32'd0);
        @(posedge clk_i);
        #1;
        m_ready = 1'b1;

        // Full FIFO: 32 words with no marker
        for (int i = 0; i < 32; i++) send_word(32'h4100_0000 + i, 0);
        check_val("full_sready", {31'd0, s_ready}, 32'd0);
        check_val("full_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        wait_idle(120);
        check_val("full_drained", exp_q.size(), 32'd0);
        send_word(MARK, 1);
        check_val("late_mark_busy", {31'd0, busy_o}, 32'd0);
        check_val("late_mark_rd", {31'd0, fifo_rd_en}, 32'd0);

        // Underrun: empty flag forced during the first drain read
        send_word(32'h4080_0000, 0);
        send_word(32'h40A0_0000, 0);
        send_word(MARK, 1);
        force_empty = 1'b1;
        @(posedge clk_i);
        #1;
        force_empty = 1'b0;
        check_val("underrun_err", {31'd0, err_o}, 32'd1);
        wait_idle(50);
        check_val("underrun_sticky", {31'd0, err_o}, 32'd1);
        check_val("underrun_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a stalled drain
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        send_word(MARK, 1);
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        check_val("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        rstn_i = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        out_cnt = 0;
        do_reset_release();
        m_ready = 1'b1;

        // Idle period in FILL
        send_word(32'h40C0_0000, 0);
        send_word(32'h40E0_0000, 0);
`ifdef NLA_SCHED_TIMEOUT_EN
        wait_idle(120);
        check_val("timeout_drained", exp_q.size(), 32'd0);
`else
        repeat (70) begin
            @(posedge clk_i);
            #1;
        end
        check_val("no_timeout_busy", {31'd0, busy_o}, 32'd1);
        check_val("no_timeout_sready", {31'd0, s_ready}, 32'd1);
        check_val("no_timeout_rd", {31'd0, fifo_rd_en}, 32'd0);
        send_word(MARK, 1);
        wait_idle(50);
        check_val("no_timeout_drained", exp_q.size(), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
